// File: rtl/ts_pcr_parse.sv
// Receive-side MPEG-TS parser: tracks 188-byte alignment on a gapped byte stream,
// reports header fields, checks continuity on one PID and decodes the adaptation-field PCR.
module ts_pcr_parse #(
  parameter bit USE_SYNC = 1'b1,
  parameter int PKT_LEN  = 188
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ts_sync,
  input  logic        ts_valid,
  input  logic [7:0]  ts_data,
  input  logic [12:0] cfg_pid,
  output logic        locked,
  output logic        hdr_valid,
  output logic [12:0] pid,
  output logic [3:0]  cc,
  output logic [1:0]  afc,
  output logic        pcr_valid,
  output logic [32:0] pcr_base,
  output logic [8:0]  pcr_ext,
  output logic        cc_err,
  output logic        sync_err
);
  localparam int            IW       = $clog2(PKT_LEN);
  localparam logic [IW-1:0] IDX_LAST = IW'(PKT_LEN - 1);

  typedef enum logic [2:0] {S_HUNT, S_HDR, S_AF, S_PAY, S_CHK} state_t;

  typedef struct packed {
    logic [12:0] pid;
    logic [3:0]  cc;
    logic [1:0]  afc;
  } hdr_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [12:0]   pid_acc_q, pid_acc_d;
  logic [7:0]    af_len_q, af_len_d;
  logic [33:0]   pcr_sr_q, pcr_sr_d;
  logic [3:0]    last_cc_q, last_cc_d;
  logic          cc_hist_q, cc_hist_d;
  hdr_t          hdr_q, hdr_d;
  logic [32:0]   pcr_base_q, pcr_base_d;
  logic [8:0]    pcr_ext_q, pcr_ext_d;
  logic          locked_q, locked_d;
  logic          hdr_valid_q, hdr_valid_d;
  logic          pcr_valid_q, pcr_valid_d;
  logic          cc_err_q, cc_err_d;
  logic          sync_err_q, sync_err_d;

  logic          is_start;
  logic [3:0]    cc_exp;

  assign is_start = ts_valid && (ts_data == 8'h47) && (ts_sync || !USE_SYNC);
  // afc[0] (payload present) is byte-3 bit 4; without payload the CC must repeat
  assign cc_exp   = ts_data[4] ? last_cc_q + 4'd1 : last_cc_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pid_acc_d   = pid_acc_q;
    af_len_d    = af_len_q;
    pcr_sr_d    = pcr_sr_q;
    last_cc_d   = last_cc_q;
    cc_hist_d   = cc_hist_q;
    hdr_d       = hdr_q;
    pcr_base_d  = pcr_base_q;
    pcr_ext_d   = pcr_ext_q;
    locked_d    = locked_q;
    hdr_valid_d = 1'b0;
    pcr_valid_d = 1'b0;
    cc_err_d    = 1'b0;
    sync_err_d  = 1'b0;

    if (ts_valid) begin
      case (state_q)
        S_HUNT: begin
          if (is_start) begin
            state_d = S_HDR;
            idx_d   = IW'(1);
          end
        end
        S_CHK: begin
          if (is_start) begin
            state_d  = S_HDR;
            idx_d    = IW'(1);
            locked_d = 1'b1;
          end else begin
            state_d    = S_HUNT;
            idx_d      = '0;
            locked_d   = 1'b0;
            sync_err_d = 1'b1;
            cc_hist_d  = 1'b0;
          end
        end
        default: begin
          if (locked_q && is_start && ts_sync) begin
            // early sync marker: treat this byte as the new packet start
            state_d    = S_HDR;
            idx_d      = IW'(1);
            locked_d   = 1'b0;
            sync_err_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
            if (state_q == S_HDR) begin
              if (idx_q == IW'(1)) begin
                pid_acc_d[12:8] = ts_data[4:0];
              end else if (idx_q == IW'(2)) begin
                pid_acc_d[7:0] = ts_data;
              end else begin
                hdr_d.pid   = pid_acc_q;
                hdr_d.cc    = ts_data[3:0];
                hdr_d.afc   = ts_data[5:4];
                hdr_valid_d = 1'b1;
                if (pid_acc_q == cfg_pid) begin
                  if (cc_hist_q && (ts_data[3:0] != cc_exp)) cc_err_d = 1'b1;
                  last_cc_d = ts_data[3:0];
                  cc_hist_d = 1'b1;
                end
                state_d = ts_data[5] ? S_AF : S_PAY;
              end
            end else if (state_q == S_AF) begin
              if (idx_q == IW'(4)) begin
                af_len_d = ts_data;
              end else if (idx_q == IW'(5)) begin
                if (!(ts_data[4] && (af_len_q >= 8'd7))) state_d = S_PAY;
              end else if (idx_q == IW'(10)) begin
                // only bit 7 (base LSB) and bit 0 (ext MSB) of byte 10 are kept
                pcr_sr_d = {pcr_sr_q[31:0], ts_data[7], ts_data[0]};
              end else if (idx_q == IW'(11)) begin
                pcr_base_d  = pcr_sr_q[33:1];
                pcr_ext_d   = {pcr_sr_q[0], ts_data};
                pcr_valid_d = 1'b1;
                state_d     = S_PAY;
              end else begin
                pcr_sr_d = {pcr_sr_q[25:0], ts_data};
              end
            end else if (idx_q == IDX_LAST) begin
              state_d = S_CHK;
              idx_d   = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HUNT;
      idx_q       <= '0;
      pid_acc_q   <= '0;
      af_len_q    <= '0;
      pcr_sr_q    <= '0;
      last_cc_q   <= '0;
      cc_hist_q   <= 1'b0;
      hdr_q       <= '0;
      pcr_base_q  <= '0;
      pcr_ext_q   <= '0;
      locked_q    <= 1'b0;
      hdr_valid_q <= 1'b0;
      pcr_valid_q <= 1'b0;
      cc_err_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pid_acc_q   <= pid_acc_d;
      af_len_q    <= af_len_d;
      pcr_sr_q    <= pcr_sr_d;
      last_cc_q   <= last_cc_d;
      cc_hist_q   <= cc_hist_d;
      hdr_q       <= hdr_d;
      pcr_base_q  <= pcr_base_d;
      pcr_ext_q   <= pcr_ext_d;
      locked_q    <= locked_d;
      hdr_valid_q <= hdr_valid_d;
      pcr_valid_q <= pcr_valid_d;
      cc_err_q    <= cc_err_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign locked    = locked_q;
  assign hdr_valid = hdr_valid_q;
  assign pid       = hdr_q.pid;
  assign cc        = hdr_q.cc;
  assign afc       = hdr_q.afc;
  assign pcr_valid = pcr_valid_q;
  assign pcr_base  = pcr_base_q;
  assign pcr_ext   = pcr_ext_q;
  assign cc_err    = cc_err_q;
  assign sync_err  = sync_err_q;

endmodule
